// File: rtl/crg_pkg.sv
// crg_pkg: shared state types and default timing constants for the clock/reset sequencer
package crg_pkg;
   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      SW_GATE,
      SW_SEL,
      SW_UNGATE
   } state_t;
   typedef enum logic {PH_A, PH_B} phase_t;
   localparam int DEF_N_DOM = 3;
   localparam int DEF_MUX_DOM = 0;
   localparam int DEF_PLL_RST_CYC = 16;
   localparam int DEF_LOCK_TMO = 65535;
   localparam int DEF_STABLE_CYC = 256;
   localparam int DEF_GAP_CYC = 8;
   localparam int DEF_CW = 16;
   // states in which a falling lock aborts the sequence
   function automatic logic lock_watched(input state_t s);
      return !(s inside {RESET_PLL, WAIT_LOCK});
   endfunction
endpackage

// File: rtl/crg_cycle_timer.sv
// crg_cycle_timer: CW-bit down-counter shared by every sequencer step interval
// clk, rst : clock and asynchronous active-high reset (reset loads RST_VAL)
// load     : reload the counter with value
// value    : interval length in cycles
// done     : high in the last cycle of the loaded interval
module crg_cycle_timer #(
   parameter int CW = 16,
   parameter logic [CW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] value,
   output logic          done
);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= RST_VAL;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   // an interval loaded with N on entry ends exactly N cycles later, as the count is about to reach 0
   assign done = cnt <= CW'(1);
endmodule

// File: rtl/crg_seq_ctrl.sv
// crg_seq_ctrl: PLL reset/lock qualification, ordered domain clock/reset release and safe BUFGMUX switching
// clk_src, rst_sys     : free-running source clock, asynchronous active-high reset
// pll_locked           : raw PLL lock (synchronized internally)
// pll_reset            : PLL reset
// clk_cen, dom_rst_n   : per-domain BUFGCE enables and active-low domain resets
// sw_req, sw_sel       : clock-switch request level and target select
// mux_sel, sw_ack      : BUFGMUX select for MUX_DOM, one-cycle switch acknowledge
// crg_ready, lock_lost : all domains running, one-cycle lock-loss pulse
// tmo_cnt              : saturating lock-timeout count
module crg_seq_ctrl
   import crg_pkg::*;
#(
   parameter int   N_DOM       = DEF_N_DOM,
   parameter int   MUX_DOM     = DEF_MUX_DOM,
   parameter logic SEL_RST     = 1'b0,
   parameter int   PLL_RST_CYC = DEF_PLL_RST_CYC,
   parameter int   LOCK_TMO    = DEF_LOCK_TMO,
   parameter int   STABLE_CYC  = DEF_STABLE_CYC,
   parameter int   GAP_CYC     = DEF_GAP_CYC,
   parameter int   CW          = DEF_CW
) (
   input  logic             clk_src,
   input  logic             rst_sys,
   input  logic             pll_locked,
   output logic             pll_reset,
   output logic [N_DOM-1:0] clk_cen,
   output logic [N_DOM-1:0] dom_rst_n,
   input  logic             sw_req,
   input  logic             sw_sel,
   output logic             mux_sel,
   output logic             sw_ack,
   output logic             crg_ready,
   output logic             lock_lost,
   output logic [7:0]       tmo_cnt
);
   localparam int IW = N_DOM > 1 ? $clog2(N_DOM) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_DOM - 1);
   (* ASYNC_REG = "TRUE" *) logic [1:0] lock_ff;
   logic locked_s;
   state_t state;
   phase_t phase;
   logic [IW-1:0] dom;
   logic [IW-1:0] dom_nxt;
   logic armed;
   logic lost;
   logic go_sw;
   logic t_load;
   logic t_done;
   logic [CW-1:0] t_val;
   always_ff @(posedge clk_src or posedge rst_sys)
      if (rst_sys) lock_ff <= '0;
      else lock_ff <= {lock_ff[0], pll_locked};
   assign locked_s = lock_ff[1];
   assign dom_nxt = dom + 1'b1;
   // the timer reloads on every state or step entry; this mirrors the transitions taken below
   always_comb begin
      lost = !locked_s && lock_watched(state);
      go_sw = state == RUN && sw_req && armed && sw_sel != mux_sel;
      t_load = lost || go_sw || (state == WAIT_LOCK && locked_s) || (t_done && state != RUN);
      t_val = lost ? CW'(PLL_RST_CYC)
            : state == RESET_PLL ? CW'(LOCK_TMO)
            : state == WAIT_LOCK ? (locked_s ? CW'(STABLE_CYC) : CW'(PLL_RST_CYC))
            : CW'(GAP_CYC);
   end
   crg_cycle_timer #(
      .CW(CW),
      .RST_VAL(CW'(PLL_RST_CYC))
   ) u_timer (
      .clk(clk_src),
      .rst(rst_sys),
      .load(t_load),
      .value(t_val),
      .done(t_done)
   );
   always_ff @(posedge clk_src or posedge rst_sys)
      if (rst_sys) begin
         state <= RESET_PLL;
         phase <= PH_A;
         dom <= '0;
         armed <= 1'b1;
         pll_reset <= 1'b1;
         clk_cen <= '0;
         dom_rst_n <= '0;
         mux_sel <= SEL_RST;
         sw_ack <= 1'b0;
         crg_ready <= 1'b0;
         lock_lost <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         sw_ack <= 1'b0;
         lock_lost <= 1'b0;
         // a request is serviced only once it has been seen low since the last ack
         if (!sw_req) armed <= 1'b1;
         if (lost) begin
            state <= RESET_PLL;
            pll_reset <= 1'b1;
            clk_cen <= '0;
            dom_rst_n <= '0;
            crg_ready <= 1'b0;
            lock_lost <= 1'b1;
         end else begin
            case (state)
               RESET_PLL:
                  if (t_done) begin
                     pll_reset <= 1'b0;
                     state <= WAIT_LOCK;
                  end
               WAIT_LOCK:
                  if (locked_s) state <= STABLE;
                  else if (t_done) begin
                     tmo_cnt <= tmo_cnt != 8'hff ? tmo_cnt + 1'b1 : tmo_cnt;
                     pll_reset <= 1'b1;
                     state <= RESET_PLL;
                  end
               STABLE:
                  if (t_done) begin
                     clk_cen[0] <= 1'b1;
                     dom <= '0;
                     phase <= PH_A;
                     state <= RELEASE;
                  end
               RELEASE:
                  if (t_done) begin
                     if (phase == PH_A) begin
                        dom_rst_n[dom] <= 1'b1;
                        phase <= PH_B;
                     end else if (dom == LAST) begin
                        crg_ready <= 1'b1;
                        state <= RUN;
                     end else begin
                        clk_cen[dom_nxt] <= 1'b1;
                        dom <= dom_nxt;
                        phase <= PH_A;
                     end
                  end
               RUN:
                  if (go_sw) begin
                     dom_rst_n[MUX_DOM] <= 1'b0;
                     crg_ready <= 1'b0;
                     phase <= PH_A;
                     state <= SW_GATE;
                  end else if (sw_req && armed) begin
                     sw_ack <= 1'b1;
                     armed <= 1'b0;
                  end
               SW_GATE:
                  if (t_done) begin
                     clk_cen[MUX_DOM] <= 1'b0;
                     phase <= PH_A;
                     state <= SW_SEL;
                  end
               SW_SEL:
                  if (t_done) begin
                     if (phase == PH_A) begin
                        mux_sel <= sw_sel;
                        phase <= PH_B;
                     end else begin
                        clk_cen[MUX_DOM] <= 1'b1;
                        phase <= PH_A;
                        state <= SW_UNGATE;
                     end
                  end
               SW_UNGATE:
                  if (t_done) begin
                     if (phase == PH_A) begin
                        dom_rst_n[MUX_DOM] <= 1'b1;
                        phase <= PH_B;
                     end else begin
                        crg_ready <= 1'b1;
                        sw_ack <= 1'b1;
                        armed <= 1'b0;
                        state <= RUN;
                     end
                  end
               default: state <= RESET_PLL;
            endcase
         end
      end
endmodule

// File: tb/tb_crg_seq_ctrl.sv
// tb_crg_seq_ctrl: directed self-checking bench for crg_seq_ctrl
module tb_crg_seq_ctrl;
   logic clk = 1'b0;
   logic rst_sys = 1'b1;
   logic pll_locked = 1'b0;
   logic sw_req = 1'b0;
   logic sw_sel = 1'b0;
   logic pll_reset;
   logic [2:0] clk_cen;
   logic [2:0] dom_rst_n;
   logic mux_sel;
   logic sw_ack;
   logic crg_ready;
   logic lock_lost;
   logic [7:0] tmo_cnt;
   int checks = 0;
   int errors = 0;
   crg_seq_ctrl #(
      .N_DOM(3),
      .MUX_DOM(0),
      .SEL_RST(1'b0),
      .PLL_RST_CYC(16),
      .LOCK_TMO(100),
      .STABLE_CYC(32),
      .GAP_CYC(4),
      .CW(16)
   ) dut (
      .clk_src(clk),
      .rst_sys(rst_sys),
      .pll_locked(pll_locked),
      .pll_reset(pll_reset),
      .clk_cen(clk_cen),
      .dom_rst_n(dom_rst_n),
      .sw_req(sw_req),
      .sw_sel(sw_sel),
      .mux_sel(mux_sel),
      .sw_ack(sw_ack),
      .crg_ready(crg_ready),
      .lock_lost(lock_lost),
      .tmo_cnt(tmo_cnt)
   );
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic test_reset();
      logic [18:0] got;
      repeat (3) @(negedge clk);
      got = {pll_reset, clk_cen, dom_rst_n, crg_ready, sw_ack, lock_lost, mux_sel, tmo_cnt};
      checks++;
      if (got !== {1'b1, 18'b0}) begin
         errors++;
         $display("FAIL reset_values got %b want %b", got, {1'b1, 18'b0});
      end
      rst_sys = 1'b0;
   endtask
   task automatic test_lock_timeout();
      logic [14:0] got;
      logic [14:0] want;
      for (int k = 1; k <= 360; k++) begin
         @(negedge clk);
         want = {(k % 116) < 16, 6'b0, 8'(k / 116)};
         got = {pll_reset, clk_cen, dom_rst_n, tmo_cnt};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL lock_timeout k=%0d got %b want %b", k, got, want);
         end
      end
      repeat (256 * 116 - 360) @(negedge clk);
      got = {pll_reset, clk_cen, dom_rst_n, tmo_cnt};
      checks++;
      if (got !== {1'b1, 6'b0, 8'hff}) begin
         errors++;
         $display("FAIL tmo_saturate got %b want %b", got, {1'b1, 6'b0, 8'hff});
      end
   endtask
   task automatic wait_ready();
      int n = 0;
      pll_locked = 1'b1;
      while (crg_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (crg_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready crg_ready got %b want 1 after %0d cycles", crg_ready, n);
      end
      checks++;
      if ({clk_cen, dom_rst_n, tmo_cnt, mux_sel} !== {6'b111111, 8'hff, 1'b0}) begin
         errors++;
         $display("FAIL ready_state got %b want %b", {clk_cen, dom_rst_n, tmo_cnt, mux_sel}, {6'b111111, 8'hff, 1'b0});
      end
   endtask
   task automatic test_switch(input logic tgt);
      logic [10:0] got;
      logic [10:0] want;
      sw_sel = tgt;
      sw_req = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         want = {1'b0, 2'b11, !(k >= 5 && k < 13), 2'b11, !(k >= 1 && k < 17), k >= 21, k == 21, 1'b0, (k >= 9) ? tgt : !tgt};
         got = {pll_reset, clk_cen, dom_rst_n, crg_ready, sw_ack, lock_lost, mux_sel};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL switch k=%0d got %b want %b", k, got, want);
         end
         if (k == 21) sw_req = 1'b0;
      end
   endtask
   task automatic test_rst_mid_switch();
      logic [18:0] got;
      sw_sel = 1'b0;
      sw_req = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if ({mux_sel, clk_cen[0], dom_rst_n[0], crg_ready} !== 4'b1000) begin
         errors++;
         $display("FAIL in_sw_sel got %b want 1000", {mux_sel, clk_cen[0], dom_rst_n[0], crg_ready});
      end
      rst_sys = 1'b1;
      #1;
      got = {pll_reset, clk_cen, dom_rst_n, crg_ready, sw_ack, lock_lost, mux_sel, tmo_cnt};
      checks++;
      if (got !== {1'b1, 18'b0}) begin
         errors++;
         $display("FAIL rst_mid_switch got %b want %b", got, {1'b1, 18'b0});
      end
      sw_req = 1'b0;
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      rst_sys = 1'b0;
   endtask
   task automatic check_bringup(input int lock_at, input int req_at, input int cen_at, input logic mx, input int ack_at, input string tag);
      logic [10:0] got;
      logic [10:0] want;
      for (int k = 1; k <= cen_at + 26; k++) begin
         @(negedge clk);
         want = {k < 16, k >= cen_at + 16, k >= cen_at + 8, k >= cen_at, k >= cen_at + 20, k >= cen_at + 12, k >= cen_at + 4, k >= cen_at + 24, k == ack_at, 1'b0, mx};
         got = {pll_reset, clk_cen, dom_rst_n, crg_ready, sw_ack, lock_lost, mux_sel};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got %b want %b", tag, k, got, want);
         end
         if (k == lock_at) pll_locked = 1'b1;
         if (k == req_at) sw_req = 1'b1;
      end
   endtask
   task automatic test_power_up();
      check_bringup(29, 0, 64, 1'b0, 0, "power_up");
   endtask
   task automatic test_lock_loss();
      logic [10:0] got;
      logic [10:0] want;
      pll_locked = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         want = k < 3 ? 11'b0_111_111_1_0_0_1 : 11'b1_000_000_0_0_1_1;
         got = {pll_reset, clk_cen, dom_rst_n, crg_ready, sw_ack, lock_lost, mux_sel};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL lock_loss k=%0d got %b want %b", k, got, want);
         end
      end
      pll_locked = 1'b1;
      check_bringup(-1, 0, 49, 1'b1, 0, "relock");
   endtask
   task automatic test_noop_ack();
      logic [10:0] got;
      logic [10:0] want;
      sw_sel = 1'b1;
      sw_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         want = {1'b0, 6'b111111, 1'b1, k == 1 || k == 5, 1'b0, 1'b1};
         got = {pll_reset, clk_cen, dom_rst_n, crg_ready, sw_ack, lock_lost, mux_sel};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL noop_ack k=%0d got %b want %b", k, got, want);
         end
         sw_req = k < 3 || k == 4;
      end
   endtask
   task automatic test_sw_during_release();
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pll_reset, crg_ready} !== 2'b10) begin
         errors++;
         $display("FAIL rel_drop got %b want 10", {pll_reset, crg_ready});
      end
      pll_locked = 1'b1;
      sw_sel = 1'b1;
      check_bringup(-1, 51, 49, 1'b1, 74, "sw_in_release");
      sw_req = 1'b0;
   endtask
   initial begin
      test_reset();
      test_lock_timeout();
      wait_ready();
      test_switch(1'b1);
      test_rst_mid_switch();
      test_power_up();
      test_switch(1'b1);
      test_lock_loss();
      test_noop_ack();
      test_sw_during_release();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
